// File: rtl/keymgr_aes_sideload_slot.sv
// Sideload key slot for the AES core. It holds one two-share masked key,
// wipes the shares with entropy on clear, and refuses an abnormal run of
// identical key loads by raising a sticky alert.
module keymgr_aes_sideload_slot #(
    parameter int unsigned KeyWidth     = 128,
    parameter int unsigned ClearCycles  = 4,
    parameter int unsigned RepeatThresh = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [KeyWidth-1:0] key_share0_i,
    input  logic [KeyWidth-1:0] key_share1_i,
    input  logic                clear_i,
    output logic                entropy_req_o,
    input  logic                entropy_ack_i,
    input  logic [KeyWidth-1:0] entropy_i,
    output logic                key_valid_o,
    output logic [KeyWidth-1:0] key_share0_o,
    output logic [KeyWidth-1:0] key_share1_o,
    output logic                busy_o,
    output logic                ack_o,
    output logic                repeat_alert_o
);

    localparam int unsigned CntW  = $clog2(RepeatThresh + 1);
    localparam int unsigned WipeW = $clog2(ClearCycles + 1);
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VALID,
        ST_RELOAD,
        ST_WIPE
    } state_e;

    state_e              state_q, state_d;
    logic [KeyWidth-1:0] share0_q, share0_d;
    logic [KeyWidth-1:0] share1_q, share1_d;
    logic [KeyWidth-1:0] last_key_q, last_key_d;
    logic [CntW-1:0]     rep_cnt_q, rep_cnt_d;
    logic [WipeW-1:0]    wipe_cnt_q, wipe_cnt_d;
    logic                alert_d;
    logic                ack_d;

    logic [KeyWidth-1:0] unmasked;
    logic [CntW-1:0]     rep_cnt_next;
    logic                load_ok;

    // Repeat-monitor candidate count for the key presented this cycle.
    always_comb begin
        unmasked     = key_share0_i ^ key_share1_i;
        rep_cnt_next = CntW'(1);
        if (unmasked == last_key_q) begin
            rep_cnt_next = (rep_cnt_q == CntMax) ? rep_cnt_q : rep_cnt_q + CntW'(1);
        end
        load_ok = load_i && !repeat_alert_o && !clear_i &&
                  ((state_q == ST_IDLE) || (state_q == ST_VALID));
    end

    // Next-state, share update and completion pulse.
    always_comb begin
        state_d    = state_q;
        share0_d   = share0_q;
        share1_d   = share1_q;
        last_key_d = last_key_q;
        rep_cnt_d  = rep_cnt_q;
        wipe_cnt_d = wipe_cnt_q;
        alert_d    = repeat_alert_o;
        ack_d      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_VALID: begin
                if (clear_i) begin
                    state_d    = ST_WIPE;
                    wipe_cnt_d = '0;
                end else if (load_ok) begin
                    last_key_d = unmasked;
                    rep_cnt_d  = rep_cnt_next;
                    if (rep_cnt_next == CntW'(RepeatThresh)) begin
                        // Refused load: never reaches the shares, slot is wiped.
                        alert_d    = 1'b1;
                        state_d    = ST_WIPE;
                        wipe_cnt_d = '0;
                    end else begin
                        share0_d = key_share0_i;
                        share1_d = key_share1_i;
                        if (state_q == ST_IDLE) begin
                            state_d = ST_VALID;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = ST_RELOAD;
                        end
                    end
                end
            end
            ST_RELOAD: begin
                if (clear_i) begin
                    state_d    = ST_WIPE;
                    wipe_cnt_d = '0;
                end else begin
                    state_d = ST_VALID;
                    ack_d   = 1'b1;
                end
            end
            ST_WIPE: begin
                if (entropy_ack_i) begin
                    share0_d = entropy_i;
                    share1_d = {entropy_i[KeyWidth-2:0], entropy_i[KeyWidth-1]};
                    if (wipe_cnt_q == WipeW'(ClearCycles - 1)) begin
                        state_d    = ST_IDLE;
                        wipe_cnt_d = '0;
                        ack_d      = 1'b1;
                    end else begin
                        wipe_cnt_d = wipe_cnt_q + WipeW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and internal registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            share0_q       <= '0;
            share1_q       <= '0;
            last_key_q     <= '0;
            rep_cnt_q      <= '0;
            wipe_cnt_q     <= '0;
            repeat_alert_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            share0_q       <= share0_d;
            share1_q       <= share1_d;
            last_key_q     <= last_key_d;
            rep_cnt_q      <= rep_cnt_d;
            wipe_cnt_q     <= wipe_cnt_d;
            repeat_alert_o <= alert_d;
        end
    end

    // Registered outputs; shares are gated to zero unless the key is valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_valid_o   <= 1'b0;
            key_share0_o  <= '0;
            key_share1_o  <= '0;
            busy_o        <= 1'b0;
            entropy_req_o <= 1'b0;
            ack_o         <= 1'b0;
        end else begin
            key_valid_o   <= (state_d == ST_VALID);
            key_share0_o  <= (state_d == ST_VALID) ? share0_d : '0;
            key_share1_o  <= (state_d == ST_VALID) ? share1_d : '0;
            busy_o        <= (state_d == ST_RELOAD) || (state_d == ST_WIPE);
            entropy_req_o <= (state_d == ST_WIPE);
            ack_o         <= ack_d;
        end
    end

endmodule

// File: tb/tb_keymgr_aes_sideload_slot.sv
// Directed bench for the AES sideload key slot.
module tb_keymgr_aes_sideload_slot;

    localparam int unsigned W = 128;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         load_i;
    logic [W-1:0] key_share0_i;
    logic [W-1:0] key_share1_i;
    logic         clear_i;
    logic         entropy_req_o;
    logic         entropy_ack_i;
    logic [W-1:0] entropy_i;
    logic         key_valid_o;
    logic [W-1:0] key_share0_o;
    logic [W-1:0] key_share1_o;
    logic         busy_o;
    logic         ack_o;
    logic         repeat_alert_o;

    int n_vec = 0;
    int n_err = 0;

    keymgr_aes_sideload_slot #(
        .KeyWidth    (W),
        .ClearCycles (4),
        .RepeatThresh(16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .load_i        (load_i),
        .key_share0_i  (key_share0_i),
        .key_share1_i  (key_share1_i),
        .clear_i       (clear_i),
        .entropy_req_o (entropy_req_o),
        .entropy_ack_i (entropy_ack_i),
        .entropy_i     (entropy_i),
        .key_valid_o   (key_valid_o),
        .key_share0_o  (key_share0_o),
        .key_share1_o  (key_share1_o),
        .busy_o        (busy_o),
        .ack_o         (ack_o),
        .repeat_alert_o(repeat_alert_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rotl1(input logic [W-1:0] x);
        return {x[W-2:0], x[W-1]};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a key for one cycle.
    task automatic do_load(input logic [W-1:0] s0, input logic [W-1:0] s1);
        key_share0_i = s0;
        key_share1_i = s1;
        load_i       = 1'b1;
        step();
        load_i       = 1'b0;
    endtask

    // Wait for ack_o within a cycle budget; a timeout is a miscompare.
    task automatic wait_ack(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (ack_o) break;
            step();
        end
        chk(tag, W'(ack_o), W'(1));
    endtask

    // Clear with entropy always available and wait for completion.
    task automatic do_wipe(input string tag);
        clear_i       = 1'b1;
        entropy_ack_i = 1'b1;
        step();
        clear_i       = 1'b0;
        wait_ack(tag);
        entropy_ack_i = 1'b0;
        step();
    endtask

    localparam logic [W-1:0] KeyA = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [W-1:0] MskA = {16{8'hA5}};
    localparam logic [W-1:0] KeyR = 128'hDEADBEEF_AE5C0FFE_BADC0FFE_01234567;
    localparam logic [W-1:0] KeyB = 128'h55AA_1234_0F0F_8888_FFFF_0000_C3C3_7E7E;

    logic [W-1:0] ent[7];
    logic [W-1:0] msk;
    int           acks;
    int           req_cycles;

    initial begin
        rst_ni        = 1'b0;
        load_i        = 1'b0;
        clear_i       = 1'b0;
        entropy_ack_i = 1'b0;
        key_share0_i  = '0;
        key_share1_i  = '0;
        entropy_i     = '0;
        for (int i = 0; i < 7; i++) ent[i] = {4{32'hC0DE_0000 + 32'(i)}} ^ {16{8'h3C}};
        step();
        step();
        chk("rst_valid", W'(key_valid_o), W'(0));
        chk("rst_share0", key_share0_o, '0);
        chk("rst_busy_ack_req_alert",
            W'({busy_o, ack_o, entropy_req_o, repeat_alert_o}), W'(0));
        rst_ni = 1'b1;
        step();

        // Load from Idle.
        do_load(KeyA ^ MskA, MskA);
        chk("idle_load_valid", W'(key_valid_o), W'(1));
        chk("idle_load_s0", key_share0_o, KeyA ^ MskA);
        chk("idle_load_s1", key_share1_o, MskA);
        chk("idle_load_ack", W'(ack_o), W'(1));
        chk("idle_load_busy", W'(busy_o), W'(0));
        step();
        chk("idle_load_ack_once", W'(ack_o), W'(0));
        chk("idle_load_hold", W'(key_valid_o), W'(1));

        // Clear from Valid with entropy always acknowledged.
        clear_i       = 1'b1;
        entropy_ack_i = 1'b1;
        step();
        clear_i    = 1'b0;
        req_cycles = 0;
        chk("wipe_entry_valid", W'(key_valid_o), W'(0));
        chk("wipe_entry_busy", W'(busy_o), W'(1));
        chk("wipe_entry_s0", key_share0_o, '0);
        for (int i = 0; i < 4; i++) begin
            if (entropy_req_o) req_cycles++;
            entropy_i = ent[i];
            step();
        end
        chk("wipe_req_cycles", W'(req_cycles), W'(4));
        chk("wipe_req_drop", W'(entropy_req_o), W'(0));
        chk("wipe_done_ack", W'(ack_o), W'(1));
        chk("wipe_done_idle", W'({key_valid_o, busy_o}), W'(0));
        chk("wipe_out_s1", key_share1_o, '0);
        chk("wipe_int_s0", dut.share0_q, ent[3]);
        chk("wipe_int_s1", dut.share1_q, rotl1(ent[3]));
        entropy_ack_i = 1'b0;
        step();
        chk("wipe_ack_once", W'(ack_o), W'(0));

        // Fifteen identical unmasked keys, different masks, clears between.
        for (int i = 1; i <= 15; i++) begin
            msk = {4{32'h1000_0000 + 32'(i)}};
            do_load(KeyR ^ msk, msk);
            chk("rep_ack", W'(ack_o), W'(1));
            chk("rep_s1", key_share1_o, msk);
            chk("rep_alert", W'(repeat_alert_o), W'(0));
            do_wipe("rep_wipe_ack");
        end
        msk = {4{32'h2000_0000}};
        do_load(KeyR ^ msk, msk);
        chk("rep16_ack", W'(ack_o), W'(0));
        chk("rep16_alert", W'(repeat_alert_o), W'(1));
        chk("rep16_valid", W'(key_valid_o), W'(0));
        chk("rep16_wipe", W'({busy_o, entropy_req_o}), W'(3));
        entropy_ack_i = 1'b1;
        wait_ack("rep16_wipe_ack");
        entropy_ack_i = 1'b0;
        step();
        do_load(KeyB ^ MskA, MskA);
        chk("alert_load_ack", W'(ack_o), W'(0));
        chk("alert_load_valid", W'(key_valid_o), W'(0));
        step();
        chk("alert_load_ignored", W'(key_valid_o), W'(0));
        do_wipe("alert_clear_ack");
        chk("alert_sticky", W'(repeat_alert_o), W'(1));
        rst_ni = 1'b0;
        #1;
        chk("alert_reset", W'(repeat_alert_o), W'(0));
        step();
        rst_ni = 1'b1;
        step();

        // Alternate two keys over 300 loads.
        do_load(KeyA ^ MskA, MskA);
        chk("alt_first_ack", W'(ack_o), W'(1));
        acks = 1;
        for (int i = 1; i < 300; i++) begin
            msk = {4{32'(i) * 32'h0101_0101}};
            if (i % 2 == 1) do_load(KeyB ^ msk, msk);
            else            do_load(KeyA ^ msk, msk);
            chk("alt_drop", W'({key_valid_o, busy_o, ack_o}), W'(3'b010));
            step();
            if (ack_o) acks++;
            chk("alt_back", W'(key_valid_o), W'(1));
            chk("alt_key", key_share0_o ^ key_share1_o, (i % 2 == 1) ? KeyB : KeyA);
        end
        chk("alt_ack_count", W'(acks), W'(300));
        chk("alt_no_alert", W'(repeat_alert_o), W'(0));

        // Clear and load together from Valid: clear wins.
        key_share0_i  = KeyR;
        key_share1_i  = '0;
        load_i        = 1'b1;
        clear_i       = 1'b1;
        entropy_ack_i = 1'b1;
        step();
        load_i  = 1'b0;
        clear_i = 1'b0;
        chk("both_busy", W'(busy_o), W'(1));
        chk("both_no_ack", W'(ack_o), W'(0));
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            if (ack_o) acks++;
            chk("both_no_key", W'(key_valid_o), W'(0));
            step();
        end
        chk("both_single_ack", W'(acks), W'(1));
        entropy_ack_i = 1'b0;

        // Clear with stalled entropy acknowledgements.
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            entropy_ack_i = (i == 0 || i == 3 || i == 4 || i == 6);
            entropy_i     = ent[i];
            step();
            if (i == 5) chk("stall_hold_s0", dut.share0_q, ent[4]);
            if (i < 6)  chk("stall_busy", W'({busy_o, ack_o}), W'(2'b10));
        end
        chk("stall_done", W'({busy_o, ack_o, entropy_req_o}), W'(3'b010));
        chk("stall_last_s1", dut.share1_q, rotl1(ent[6]));
        entropy_ack_i = 1'b0;
        step();

        // Reset in the middle of a stalled wipe.
        clear_i = 1'b1;
        step();
        clear_i       = 1'b0;
        entropy_ack_i = 1'b1;
        entropy_i     = ent[2];
        step();
        entropy_ack_i = 1'b0;
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_out", W'({key_valid_o, busy_o, ack_o, entropy_req_o, repeat_alert_o}), W'(0));
        chk("mid_rst_s0", dut.share0_q, '0);
        step();
        rst_ni = 1'b1;
        step();
        chk("mid_rst_idle", W'({key_valid_o, busy_o}), W'(0));
        do_load(KeyB ^ MskA, MskA);
        chk("post_rst_load", W'({key_valid_o, ack_o}), W'(2'b11));
        chk("post_rst_key", key_share0_o, KeyB ^ MskA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keymgr_aes_sideload_slot.md
Name: keymgr_aes_sideload_slot

Overview:
- Key-manager-side provider of the two-share sideload key consumed by aes_core via keymgr_key_i (hw_key_req_t).
- Holds one masked key and drives valid plus both shares.
- Wipes the key with entropy on clear.
- Runs a repeated-key monitor: an abnormal run of identical key loads is refused and raises a sticky alert instead of propagating the pattern downstream.

Parameters:
- KeyWidth, 128, width of each key share.
- ClearCycles, 4, number of acknowledged entropy words written over both shares during a wipe (>=1).
- RepeatThresh, 16, count of consecutive identical unmasked key loads that trips the monitor (>=2).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- load_i  input  1  single-cycle request to load the key.
- key_share0_i  input  KeyWidth  masked key share 0.
- key_share1_i  input  KeyWidth  mask share 1; unmasked key = share0 ^ share1.
- clear_i  input  1  request to wipe the slot.
- entropy_req_o  output  1  entropy request during a wipe.
- entropy_ack_i  input  1  entropy word valid this cycle.
- entropy_i  input  KeyWidth  wipe data.
- key_valid_o  output  1  sideload key valid; maps to keymgr_key_i.valid.
- key_share0_o  output  KeyWidth  maps to keymgr_key_i.key[0].
- key_share1_o  output  KeyWidth  maps to keymgr_key_i.key[1].
- busy_o  output  1  reload or wipe in progress.
- ack_o  output  1  one-cycle pulse when a load or wipe completes.
- repeat_alert_o  output  1  sticky repeated-key alert.

Behaviour:
Reset:
- All outputs 0; state Idle.
- Share registers, last-key register and repeat counter are 0.
- Reset asserted mid-operation aborts it with the same values.

Output gating:
- key_share*_o are forced to 0 whenever key_valid_o=0, so entropy is never exposed.

States: Idle, Valid, Reload, Wipe.

Idle:
- load_i accepted -> capture shares at that edge.
- Next cycle: Valid, key_valid_o=1, ack_o=1.

Valid:
- load_i accepted -> capture the new shares; go to Reload.
- Reload holds key_valid_o=0 and busy_o=1 for exactly one cycle.
- Then return to Valid with key_valid_o=1 and ack_o=1. Consumers always see a valid drop between distinct loads.

Clear (from Idle, Valid or Reload):
- Next cycle: Wipe, key_valid_o=0, busy_o=1, entropy_req_o=1.
- Each cycle with entropy_ack_i=1: share0 <= entropy_i, share1 <= entropy_i rotated left by 1; wipe counter increments.
- Acks are counted only when they arrive; a stall holds the Wipe state.
- After ClearCycles acks: entropy_req_o drops, go to Idle, ack_o=1 in the first Idle cycle.
- load_i and clear_i are ignored during Wipe.
- clear_i and load_i asserted in the same cycle: clear wins; the load is dropped with no ack.

Repeat monitor (evaluated on every accepted load):
- u = key_share0_i ^ key_share1_i.
- If u == last-key register, counter = counter+1 (saturating); otherwise counter = 1. Then last-key register <= u.
- Counter width is clog2(RepeatThresh+1).
- Clears do not reset the counter or the last-key register; only rst_ni does.
- The load that makes counter == RepeatThresh is refused:
  - no capture, no ack;
  - repeat_alert_o=1 next cycle;
  - forced Wipe (same as clear).
- While repeat_alert_o=1, every load_i is ignored (no ack). clear_i still works.
- The alert clears only on reset.

Test Plan:
- Idle, load share0=0123456789ABCDEF_FEDCBA9876543210^M, share1=M (M=A5A5...A5) -> next cycle key_valid_o=1, outputs equal the inputs, ack_o pulses once, busy_o=0.
- Valid, clear with entropy_ack_i high, ClearCycles=4 -> key_valid_o=0 next cycle; entropy_req_o high exactly 4 cycles; ack_o pulses; key_share*_o=0; internal shares hold entropy-derived data, not the key.
- 15 loads of key DEADBEEF_AE5C0FFE_BADC0FFE_01234567, each with a different mask, interleaved with clears -> all acked, no alert.
  - 16th load -> refused, no ack, repeat_alert_o=1, wipe runs.
  - Any further load -> ignored.
  - Alert clears only on rst_ni.
- Alternate two distinct keys for 300 loads -> every load acked, repeat_alert_o stays 0, one-cycle valid drop observed on each reload.
- clear_i and load_i asserted in the same cycle from Valid -> Wipe entered, new key never appears, single ack_o at wipe end.
- Clear with entropy_ack_i toggling 1,0,0,1,1,0,1 -> exactly 4 acked writes before Idle.
- Assert rst_ni low during the stall -> all outputs 0 asynchronously, Idle after release.
